snake_tile_renderer: RTL and testbench

Pixel-colour source for the 800x600 VGA output stage. It holds the snake game board as a tile map written by the game logic. For every pixel coordinate (x, y) requested by the VGA timing stage, it returns a 6-bit RRGGBB colour after a fixed pipeline delay. It sits directly upstream of the VGA output stage: it consumes that stage's x/y and drives its rgb_data input.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_board_ram.sv | 23 ++
 rtl/snake_tile_renderer.sv | 156 +++++++++++++++
 tb/tb_snake_tile_renderer.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake tile renderer.
// Optional build macro: SNAKE_GRID_EN (grid lines and border ring).
package snake_pkg;

  localparam int TILE_SHIFT = 4;
  localparam int COLS       = 50;
  localparam int ROWS       = 38;
  localparam int DEPTH      = COLS * ROWS;
  localparam int AW         = 11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BODY  = 2'd1,
    HEAD  = 2'd2,
    FOOD  = 2'd3
  } tile_t;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [5:0] COL_EMPTY  = 6'h00;
  localparam logic [5:0] COL_BODY   = 6'h0C;
  localparam logic [5:0] COL_HEAD   = 6'h3C;
  localparam logic [5:0] COL_FOOD   = 6'h30;
  localparam logic [5:0] COL_GRID   = 6'h15;
  localparam logic [5:0] COL_BORDER = 6'h2A;

endpackage

// File: rtl/snake_board_ram.sv
// Board tile store: simple dual-port, read-first, registered read.
// Maps onto one block RAM; no reset on the array or read register.
module snake_board_ram
  import snake_pkg::*;
(
  input  logic          clk_fpga,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [1:0]    rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk_fpga) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/snake_tile_renderer.sv
// Tile-map pixel source for the 800x600 VGA stage, 2-cycle latency.
// Optional build macro: SNAKE_GRID_EN (grid lines and border ring).
module snake_tile_renderer
  import snake_pkg::*;
#(
  parameter int H_ACT = 800,
  parameter int V_ACT = 600
) (
  input  logic        clk_fpga,
  input  logic        rst,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [5:0]  rgb_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  input  logic        clear,
  output logic        busy
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state_q, state_n;
  logic [AW-1:0] addr_q, addr_n;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [1:0]    ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [1:0]    rd_data;

  logic [AW-1:0] col, row, tile_addr;
  logic          in_range;
  logic          in_range_q;
  logic [3:0]    xo_q, yo_q;
  logic          eye;
  logic [5:0]    rgb_n;

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      state_q <= CLEAR;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    busy      = 1'b0;
    wr_ready  = 1'b0;
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    unique case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        ram_we    = 1'b1;
        ram_waddr = addr_q;
        ram_wdata = EMPTY;
        if (clear) begin
          addr_n = '0;
        end else if (addr_q == LAST) begin
          state_n = IDLE;
        end else begin
          addr_n = addr_q + 1'b1;
        end
      end
      IDLE: begin
        wr_ready = !clear;
        // out-of-board writes still handshake but never reach the RAM
        ram_we   = wr_valid && !clear &&
                   (wr_addr < AW'(DEPTH));
        if (clear) begin
          state_n = CLEAR;
          addr_n  = '0;
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // row*50 as shifts and adds
  assign col       = AW'(x >> TILE_SHIFT);
  assign row       = AW'(y >> TILE_SHIFT);
  assign tile_addr = (row << 5) + (row << 4) +
                     (row << 1) + col;
  assign in_range  = (x < 12'(H_ACT)) &&
                     (y < 12'(V_ACT));
  assign ram_raddr = in_range ? tile_addr : '0;

  snake_board_ram u_ram (
    .clk_fpga (clk_fpga),
    .we       (ram_we),
    .waddr    (ram_waddr),
    .wdata    (ram_wdata),
    .raddr    (ram_raddr),
    .rdata    (rd_data)
  );

`ifdef SNAKE_GRID_EN
  logic border, border_q;
  assign border = (col == '0) ||
                  (col == AW'(COLS - 1)) ||
                  (row == '0) ||
                  (row == AW'(ROWS - 1));
`endif

  always_ff @(posedge clk_fpga) begin
    if (rst) begin
      in_range_q <= 1'b0;
      xo_q       <= '0;
      yo_q       <= '0;
      rgb_data   <= '0;
`ifdef SNAKE_GRID_EN
      border_q   <= 1'b0;
`endif
    end else begin
      in_range_q <= in_range;
      xo_q       <= x[3:0];
      yo_q       <= y[3:0];
      rgb_data   <= rgb_n;
`ifdef SNAKE_GRID_EN
      border_q   <= border;
`endif
    end
  end

  assign eye = (xo_q == 4'd7 || xo_q == 4'd8) &&
               (yo_q == 4'd7 || yo_q == 4'd8);

  always_comb begin
    rgb_n = COL_EMPTY;
    if (in_range_q) begin
      unique case (tile_t'(rd_data))
        EMPTY: rgb_n = COL_EMPTY;
        BODY:  rgb_n = COL_BODY;
        HEAD:  rgb_n = eye ? COL_EMPTY : COL_HEAD;
        FOOD:  rgb_n = COL_FOOD;
        default: rgb_n = COL_EMPTY;
      endcase
`ifdef SNAKE_GRID_EN
      if (border_q) begin
        rgb_n = COL_BORDER;
      end else if (rd_data == EMPTY &&
                   (xo_q == '0 || yo_q == '0)) begin
        rgb_n = COL_GRID;
      end
`endif
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Self-checking bench for snake_tile_renderer against a tile-map model.
// Honours SNAKE_GRID_EN in the reference colour function.
module tb_snake_tile_renderer;

  logic        clk_fpga = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic [5:0]  rgb_data;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [10:0] wr_addr = '0;
  logic [1:0]  wr_data = '0;
  logic        clear = 1'b0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int tiles [1900];

  always #10 clk_fpga = ~clk_fpga;

  snake_tile_renderer dut (
    .clk_fpga (clk_fpga),
    .rst      (rst),
    .x        (x),
    .y        (y),
    .rgb_data (rgb_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .clear    (clear),
    .busy     (busy)
  );

  function automatic logic [5:0] ref_px(int px, int py);
    int c, r, t, ox, oy;
    if (px >= 800 || py >= 600) return 6'h00;
    c  = px / 16;
    r  = py / 16;
    ox = px % 16;
    oy = py % 16;
`ifdef SNAKE_GRID_EN
    if (c == 0 || c == 49 || r == 0 || r == 37) return 6'h2A;
`endif
    t = tiles[r * 50 + c];
`ifdef SNAKE_GRID_EN
    if (t == 0 && (ox == 0 || oy == 0)) return 6'h15;
`endif
    case (t)
      1: return 6'h0C;
      2: return ((ox == 7 || ox == 8) && (oy == 7 || oy == 8))
                ? 6'h00 : 6'h3C;
      3: return 6'h30;
      default: return 6'h00;
    endcase
  endfunction

  task automatic model_clear();
    foreach (tiles[i]) tiles[i] = 0;
  endtask

  task automatic px(input int px_x, input int px_y,
                    output logic [5:0] got);
    x = 12'(px_x);
    y = 12'(px_y);
    @(posedge clk_fpga);
    @(posedge clk_fpga);
    #1;
    got = rgb_data;
  endtask

  task automatic do_write(input int a, input int d,
                          output logic acc);
    wr_valid = 1'b1;
    wr_addr  = 11'(a);
    wr_data  = 2'(d);
    #1;
    acc = wr_ready;
    @(posedge clk_fpga);
    #1;
    wr_valid = 1'b0;
    if (acc && a < 1900) tiles[a] = d;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy && cnt < 3000) begin
      @(posedge clk_fpga);
      #1;
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    repeat (3) @(posedge clk_fpga);
    #1;
    n_checks++;
    if (rgb_data !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_rgb got %h want 00", rgb_data);
    end
    n_checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags busy=%b rdy=%b want 1/0",
               busy, wr_ready);
    end
    rst = 1'b0;
    model_clear();
    wait_idle(cnt);
    n_checks++;
    if (cnt != 1900) begin
      n_fail++;
      $display("FAIL reset_sweep cycles %0d want 1900", cnt);
    end
    n_checks++;
    if (wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready got %b want 1", wr_ready);
    end
  endtask

  task automatic test_scan();
    int qx[$], qy[$];
    logic [5:0] want [$];
    logic [5:0] exp;
    int bad = 0;
    for (int t = 0; t < 1900; t++) begin
      qx.push_back((t % 50) * 16 + $urandom_range(0, 15));
      qy.push_back((t / 50) * 16 + $urandom_range(0, 15));
    end
    for (int i = 0; i < 100; i++) begin
      qx.push_back($urandom_range(0, 4095));
      qy.push_back($urandom_range(0, 4095));
    end
    for (int i = 0; i <= qx.size(); i++) begin
      if (i < qx.size()) begin
        x = 12'(qx[i]);
        y = 12'(qy[i]);
        want.push_back(ref_px(qx[i], qy[i]));
      end
      @(posedge clk_fpga);
      #1;
      if (i >= 1) begin
        exp = want.pop_front();
        n_checks++;
        if (rgb_data !== exp) begin
          n_fail++;
          if (bad++ < 5)
            $display("FAIL scan (%0d,%0d) got %h want %h",
                     qx[i-1], qy[i-1], rgb_data, exp);
        end
      end
    end
  endtask

  task automatic test_write_read();
    logic acc;
    logic [5:0] got;
    do_write(51, 3, acc);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL food_write acc %b want 1", acc);
    end
    px(20, 16, got);
    n_checks++;
    if (got !== ref_px(20, 16)) begin
      n_fail++;
      $display("FAIL food_px got %h want %h", got, ref_px(20, 16));
    end
    px(15, 16, got);
    n_checks++;
    if (got !== ref_px(15, 16)) begin
      n_fail++;
      $display("FAIL food_left got %h want %h", got, ref_px(15, 16));
    end
  endtask

  task automatic test_head_eye();
    logic acc;
    logic [5:0] got;
    int pts [5][2] = '{'{7, 7}, '{0, 0}, '{9, 9}, '{8, 7}, '{6, 8}};
    do_write(0, 2, acc);
    for (int i = 0; i < 5; i++) begin
      px(pts[i][0], pts[i][1], got);
      n_checks++;
      if (got !== ref_px(pts[i][0], pts[i][1])) begin
        n_fail++;
        $display("FAIL head_px (%0d,%0d) got %h want %h",
                 pts[i][0], pts[i][1], got,
                 ref_px(pts[i][0], pts[i][1]));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic acc;
    logic [5:0] got;
    do_write(49, 1, acc);
    px(800, 0, got);
    n_checks++;
    if (got !== 6'h00) begin
      n_fail++;
      $display("FAIL oob_x got %h want 00", got);
    end
    px(0, 600, got);
    n_checks++;
    if (got !== 6'h00) begin
      n_fail++;
      $display("FAIL oob_y got %h want 00", got);
    end
    do_write(1900, 1, acc);
    n_checks++;
    if (acc !== 1'b1) begin
      n_fail++;
      $display("FAIL oob_write acc %b want 1", acc);
    end
    px(50 * 16 - 5, 3, got);
    n_checks++;
    if (got !== ref_px(795, 3)) begin
      n_fail++;
      $display("FAIL oob_alias got %h want %h", got, ref_px(795, 3));
    end
  endtask

  task automatic test_read_first();
    int d;
    logic [5:0] old_c, new_c;
    d = (tiles[105] == 1) ? 3 : 1;
    x = 12'(5 * 16 + 3);
    y = 12'(35);
    old_c = ref_px(83, 35);
    wr_valid = 1'b1;
    wr_addr  = 11'd105;
    wr_data  = 2'(d);
    @(posedge clk_fpga);
    #1;
    wr_valid = 1'b0;
    tiles[105] = d;
    new_c = ref_px(83, 35);
    @(posedge clk_fpga);
    #1;
    n_checks++;
    if (rgb_data !== old_c) begin
      n_fail++;
      $display("FAIL read_first_old got %h want %h", rgb_data, old_c);
    end
    @(posedge clk_fpga);
    #1;
    n_checks++;
    if (rgb_data !== new_c) begin
      n_fail++;
      $display("FAIL read_first_new got %h want %h", rgb_data, new_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] want [$];
    int lx [$], ly [$];
    logic [5:0] exp;
    int bad = 0;
    int a;
    for (int i = 0; i <= 600; i++) begin
      if (i < 600) begin
        lx.push_back($urandom_range(0, 820));
        ly.push_back($urandom_range(0, 620));
        x = 12'(lx[i]);
        y = 12'(ly[i]);
        want.push_back(ref_px(lx[i], ly[i]));
        wr_valid = ($urandom_range(0, 1) == 1);
        a = ($urandom_range(0, 15) == 0) ? $urandom_range(1900, 2047)
                                           : $urandom_range(0, 1899);
        wr_addr = 11'(a);
        wr_data = 2'($urandom_range(0, 3));
        if (wr_valid) begin
          #1;
          n_checks++;
          if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready got %b want 1", wr_ready);
          end
          if (a < 1900) tiles[a] = int'(wr_data);
        end
      end else begin
        wr_valid = 1'b0;
      end
      @(posedge clk_fpga);
      #1;
      if (i >= 1) begin
        exp = want.pop_front();
        n_checks++;
        if (rgb_data !== exp) begin
          n_fail++;
          if (bad++ < 5)
            $display("FAIL b2b (%0d,%0d) got %h want %h",
                     lx[i-1], ly[i-1], rgb_data, exp);
        end
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_clear_write();
    int cnt;
    logic [5:0] got;
    logic acc;
    do_write(5, 2, acc);
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 11'd5;
    wr_data  = 2'd1;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_beats_write rdy %b want 0", wr_ready);
    end
    @(posedge clk_fpga);
    #1;
    clear    = 1'b0;
    wr_valid = 1'b0;
    model_clear();
    n_checks++;
    if (busy !== 1'b1 || wr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_busy busy=%b rdy=%b want 1/0",
               busy, wr_ready);
    end
    wait_idle(cnt);
    n_checks++;
    if (cnt != 1900) begin
      n_fail++;
      $display("FAIL clear_sweep cycles %0d want 1900", cnt);
    end
    px(5 * 16 + 4, 4, got);
    n_checks++;
    if (got !== ref_px(84, 4)) begin
      n_fail++;
      $display("FAIL clear_tile5 got %h want %h", got, ref_px(84, 4));
    end
  endtask

  task automatic test_clear_restart();
    int cnt;
    logic acc;
    logic [5:0] got;
    do_write(500, 3, acc);
    clear = 1'b1;
    @(posedge clk_fpga);
    #1;
    clear = 1'b0;
    repeat (700) @(posedge clk_fpga);
    #1;
    clear = 1'b1;
    @(posedge clk_fpga);
    #1;
    clear = 1'b0;
    model_clear();
    wait_idle(cnt);
    n_checks++;
    if (cnt != 1900) begin
      n_fail++;
      $display("FAIL clear_restart cycles %0d want 1900", cnt);
    end
    px(0 * 16 + 5, 10 * 16 + 5, got);
    n_checks++;
    if (got !== ref_px(5, 165)) begin
      n_fail++;
      $display("FAIL restart_tile500 got %h want %h",
               got, ref_px(5, 165));
    end
  endtask

`ifdef SNAKE_GRID_EN
  task automatic test_grid();
    logic [5:0] got;
    px(0, 0, got);
    n_checks++;
    if (got !== 6'h2A) begin
      n_fail++;
      $display("FAIL grid_border got %h want 2a", got);
    end
    px(32, 48, got);
    n_checks++;
    if (got !== 6'h15) begin
      n_fail++;
      $display("FAIL grid_line got %h want 15", got);
    end
    px(33, 49, got);
    n_checks++;
    if (got !== 6'h00) begin
      n_fail++;
      $display("FAIL grid_inner got %h want 00", got);
    end
  endtask
`endif

  initial begin
    @(posedge clk_fpga);
    #1;
    test_reset();
    test_scan();
    test_write_read();
    test_head_eye();
    test_out_of_range();
    test_read_first();
    test_back_to_back();
    test_clear_write();
`ifdef SNAKE_GRID_EN
    test_grid();
`endif
    test_clear_restart();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
